// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Request-side driver for the 32-bit ALU datapath. It accepts one op request
//   over a valid/ready handshake and decodes the opcode into the ALU's 5-bit
//   control_signal {logic_sel, arith_sel, sub_sel, mode[1:0]}. It then drives
//   registered ALU inputs, holds them for SETTLE_CYCLES, captures aluout/flags,
//   and returns result/flags/error over a second valid/ready handshake.
//
// Parameters
//   SETTLE_CYCLES : cycles the ALU inputs are held before capture (1..15)
//   OP_W          : request opcode width (>= 4)
//
// Ports
//   clk, reset                        : clock, synchronous active-high reset
//   req_valid/req_ready               : request handshake
//   req_op, req_a, req_b, req_shamt   : opcode, operands, immediate shift amount
//   alu_operand1/2, alu_control_signal, alu_sh_amt : registered ALU inputs
//   alu_aluout, alu_flags             : ALU result and {Z,S,C,V}
//   rsp_valid/rsp_ready               : response handshake
//   rsp_result, rsp_flags, rsp_err    : captured result, flags, illegal-op flag
//   status_flags                      : only with ALU_STATUS_REG_EN; flags of
//                                       the last legal completed op
//
// Configuration macro: ALU_STATUS_REG_EN
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned OP_W          = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [4:0]      req_shamt,
  output logic [31:0]     alu_operand1,
  output logic [31:0]     alu_operand2,
  output logic [4:0]      alu_control_signal,
  output logic [4:0]      alu_sh_amt,
  input  logic [31:0]     alu_aluout,
  input  logic [3:0]      alu_flags,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_result,
  output logic [3:0]      rsp_flags,
  output logic            rsp_err
`ifdef ALU_STATUS_REG_EN
  ,
  output logic [3:0]      status_flags
`endif
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 5;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  // Elaboration guards on parameter ranges
  if ((SETTLE_CYCLES == 0) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
    $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
  end
  if (OP_W < 4) begin : g_bad_opw
    $error("alu_op_sequencer: OP_W must be at least 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   settle_cnt;
  logic               cmp_op;

  logic [CTRL_W-1:0]  dec_ctrl;
  logic               dec_legal;
  logic               dec_cmp;

  // Opcode decode; CMP reuses the SUB control word and only keeps the flags
  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    dec_cmp   = 1'b0;
    case (req_op)
      OP_W'(0): dec_ctrl = 5'b01000;
      OP_W'(1): dec_ctrl = 5'b01100;
      OP_W'(2): dec_ctrl = 5'b10000;
      OP_W'(3): dec_ctrl = 5'b10100;
      OP_W'(4): dec_ctrl = 5'b00000;
      OP_W'(5): dec_ctrl = 5'b00001;
      OP_W'(6): dec_ctrl = 5'b00010;
      OP_W'(7): dec_ctrl = 5'b00011;
      OP_W'(8): begin
        dec_ctrl = 5'b01100;
        dec_cmp  = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Sequencer FSM with registered handshake and datapath outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      settle_cnt         <= '0;
      cmp_op             <= 1'b0;
      req_ready          <= 1'b1;
      rsp_valid          <= 1'b0;
      rsp_result         <= '0;
      rsp_flags          <= '0;
      rsp_err            <= 1'b0;
      alu_operand1       <= '0;
      alu_operand2       <= '0;
      alu_control_signal <= '0;
      alu_sh_amt         <= '0;
`ifdef ALU_STATUS_REG_EN
      status_flags       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (dec_legal) begin
              alu_operand1       <= req_a;
              alu_operand2       <= req_b;
              alu_control_signal <= dec_ctrl;
              alu_sh_amt         <= req_shamt;
              cmp_op             <= dec_cmp;
              settle_cnt         <= '0;
              state              <= ST_ISSUE;
            end else begin
              // Illegal op answers immediately; ALU ports keep their values
              rsp_result <= '0;
              rsp_flags  <= '0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end
          end
        end

        ST_ISSUE: begin
          if (settle_cnt == LAST_CNT) begin
            rsp_result <= cmp_op ? DATA_W'(0) : alu_aluout;
            rsp_flags  <= FLAG_W'(alu_flags);
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            settle_cnt <= '0;
            state      <= ST_RESP;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
`ifdef ALU_STATUS_REG_EN
            if (!rsp_err) begin
              status_flags <= rsp_flags;
            end
`endif
          end
        end

        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Bench for alu_op_sequencer: a behavioural ALU answers the DUT's ALU ports,
//   and a reference model computes each op's result/flags/control word directly
//   from the request. Directed scenarios plus randomized op streams.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int unsigned SETTLE = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_shamt;
  logic [31:0] alu_operand1;
  logic [31:0] alu_operand2;
  logic [4:0]  alu_control_signal;
  logic [4:0]  alu_sh_amt;
  logic [31:0] alu_aluout;
  logic [3:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
`ifdef ALU_STATUS_REG_EN
  logic [3:0]  status_flags;
`endif

  int checks   = 0;
  int failures = 0;

  // Expected ALU-port contents (last legal issue) and status register
  logic [31:0] last_a, last_b;
  logic [4:0]  last_ctrl, last_sh;
  logic [3:0]  st_exp;
  time         t_acc;

  alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .OP_W(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_op             (req_op),
    .req_a              (req_a),
    .req_b              (req_b),
    .req_shamt          (req_shamt),
    .alu_operand1       (alu_operand1),
    .alu_operand2       (alu_operand2),
    .alu_control_signal (alu_control_signal),
    .alu_sh_amt         (alu_sh_amt),
    .alu_aluout         (alu_aluout),
    .alu_flags          (alu_flags),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_result         (rsp_result),
    .rsp_flags          (rsp_flags),
    .rsp_err            (rsp_err)
`ifdef ALU_STATUS_REG_EN
    ,
    .status_flags       (status_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU sitting on the DUT's ALU ports
  logic [32:0] alu_t;
  logic [31:0] alu_r;
  logic        alu_c, alu_v;
  always_comb begin
    alu_t = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_control_signal)
      5'b01000: begin
        alu_t = {1'b0, alu_operand1} + {1'b0, alu_operand2};
        alu_r = alu_t[31:0];
        alu_c = alu_t[32];
        alu_v = (alu_operand1[31] == alu_operand2[31]) && (alu_r[31] != alu_operand1[31]);
      end
      5'b01100: begin
        alu_t = {1'b0, alu_operand1} + {1'b0, ~alu_operand2} + 33'd1;
        alu_r = alu_t[31:0];
        alu_c = alu_t[32];
        alu_v = (alu_operand1[31] != alu_operand2[31]) && (alu_r[31] != alu_operand1[31]);
      end
      5'b10000: alu_r = alu_operand1 & alu_operand2;
      5'b10100: alu_r = alu_operand1 | alu_operand2;
      5'b00000: alu_r = alu_operand1 << alu_sh_amt;
      5'b00001: alu_r = alu_operand1 >> alu_sh_amt;
      5'b00010: alu_r = $signed(alu_operand1) >>> alu_sh_amt;
      5'b00011: alu_r = alu_operand1 << alu_operand2[4:0];
      default:  alu_r = '0;
    endcase
  end
  assign alu_aluout = alu_r;
  assign alu_flags  = {(alu_r == 32'd0), alu_r[31], alu_c, alu_v};

  // Reference model: op semantics from plain arithmetic on the request
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, output logic [31:0] r, output logic [3:0] f,
                                 output logic err, output logic [4:0] ctrl);
    longint unsigned ua, ub;
    longint sa, sb, t;
    logic c, v;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0; err = 1'b0; ctrl = '0; t = 0;
    case (op)
      4'd0: begin
        r = 32'(ua + ub); c = ((ua + ub) > 64'hFFFF_FFFF);
        t = sa + sb; v = (t > SMAX) || (t < SMIN); ctrl = 5'b01000;
      end
      4'd1, 4'd8: begin
        r = 32'(ua - ub); c = (ua >= ub);
        t = sa - sb; v = (t > SMAX) || (t < SMIN); ctrl = 5'b01100;
      end
      4'd2: begin r = a & b; ctrl = 5'b10000; end
      4'd3: begin r = a | b; ctrl = 5'b10100; end
      4'd4: begin r = a << sh; ctrl = 5'b00000; end
      4'd5: begin r = a >> sh; ctrl = 5'b00001; end
      4'd6: begin r = 32'(sa >>> sh); ctrl = 5'b00010; end
      4'd7: begin r = a << b[4:0]; ctrl = 5'b00011; end
      default: err = 1'b1;
    endcase
    f = err ? 4'b0000 : {(r == 32'd0), r[31], c, v};
    if (op == 4'd8) r = '0;
  endfunction

  task automatic apply_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    last_a = '0; last_b = '0; last_ctrl = '0; last_sh = '0; st_exp = '0;
  endtask

  // One transaction, entered and left just after a falling edge
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input int hold, input string tag);
    logic [31:0] er;
    logic [3:0]  ef;
    logic        ee;
    logic [4:0]  ec;
    int          lat;
    bit          seen;
    ref_op(op, a, b, sh, er, ef, ee, ec);
    lat = ee ? 1 : int'(SETTLE) + 1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL %s req_ready_idle got=%b exp=1", tag, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_shamt = sh;
    @(posedge clk);
    t_acc = $time;
    if (!ee) begin last_a = a; last_b = b; last_ctrl = ec; last_sh = sh; end
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Garbage on req_* while busy must be ignored
        req_valid = 1'b0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
        req_shamt = 5'($urandom);
        if (!ee) begin
          checks++;
          if (alu_operand1 !== a || alu_operand2 !== b || alu_control_signal !== ec || alu_sh_amt !== sh) begin
            failures++;
            $display("FAIL %s alu_issue got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", tag, alu_operand1, alu_operand2,
                     alu_control_signal, alu_sh_amt, a, b, ec, sh);
          end
        end
      end
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (k != lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", tag, k, lat); end
      end else if (k < lat) begin
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL %s req_ready_busy got=%b exp=0", tag, req_ready); end
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s rsp_timeout got=no_rsp exp=rsp_at_%0d", tag, lat);
      apply_reset();
      return;
    end
    checks++;
    if (alu_operand1 !== last_a || alu_operand2 !== last_b || alu_control_signal !== last_ctrl || alu_sh_amt !== last_sh) begin
      failures++;
      $display("FAIL %s alu_hold got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", tag, alu_operand1, alu_operand2,
               alu_control_signal, alu_sh_amt, last_a, last_b, last_ctrl, last_sh);
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_flags !== ef || rsp_err !== ee) begin
        failures++;
        $display("FAIL %s rsp(h=%0d) got=v%b r=%h f=%b e=%b exp=v1 r=%h f=%b e=%b", tag, h, rsp_valid,
                 rsp_result, rsp_flags, rsp_err, er, ef, ee);
      end
      checks++;
      if (req_ready !== 1'b0) begin failures++; $display("FAIL %s req_ready_resp got=%b exp=0", tag, req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (!ee) st_exp = ef;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL %s done got=v%b rdy%b exp=v0 rdy1", tag, rsp_valid, req_ready);
    end
`ifdef ALU_STATUS_REG_EN
    checks++;
    if (status_flags !== st_exp) begin
      failures++; $display("FAIL %s status_flags got=%b exp=%b", tag, status_flags, st_exp);
    end
`endif
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_flags !== 4'd0 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL reset_rsp got=rdy%b v%b r=%h f=%b e=%b exp=rdy1 v0 r=0 f=0 e=0", req_ready,
                           rsp_valid, rsp_result, rsp_flags, rsp_err);
    end
    checks++;
    if (alu_operand1 !== 32'd0 || alu_operand2 !== 32'd0 || alu_control_signal !== 5'd0 || alu_sh_amt !== 5'd0) begin
      failures++; $display("FAIL reset_alu got=%h/%h/%b/%0d exp=0/0/0/0", alu_operand1, alu_operand2,
                           alu_control_signal, alu_sh_amt);
    end
`ifdef ALU_STATUS_REG_EN
    checks++;
    if (status_flags !== 4'd0) begin failures++; $display("FAIL reset_status got=%b exp=0000", status_flags); end
`endif
  endtask

  task automatic test_directed();
    do_op(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, "add_wrap");
    do_op(4'd6, 32'h8000_0000, 32'd0, 5'd4, 0, "sra");
    do_op(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 0, "illegal12");
    do_op(4'd8, 32'd5, 32'd5, 5'd0, 3, "cmp_hold");
    do_op(4'd7, 32'h0000_0003, 32'hFFFF_FFE4, 5'd1, 1, "sllv");
    do_op(4'd1, 32'h8000_0000, 32'd1, 5'd0, 0, "sub_ovf");
  endtask

  task automatic test_reset_mid_flight();
    req_valid = 1'b1; req_op = 4'd0; req_a = 32'hDEAD_BEEF; req_b = 32'h0101_0101; req_shamt = 5'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_a = '0; last_b = '0; last_ctrl = '0; last_sh = '0; st_exp = '0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_flags !== 4'd0 || rsp_err !== 1'b0 ||
        alu_operand1 !== 32'd0 || alu_operand2 !== 32'd0 || alu_control_signal !== 5'd0 || alu_sh_amt !== 5'd0) begin
      failures++; $display("FAIL mid_issue_reset got=rdy%b v%b op1=%h op2=%h ctl=%b exp=rdy1 v0 zeros", req_ready,
                           rsp_valid, alu_operand1, alu_operand2, alu_control_signal);
    end
    for (int i = 0; i < int'(SETTLE) + 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_issue_no_rsp got=%b exp=0", rsp_valid); end
    end
    // Reset while a response is pending
    req_valid = 1'b1; req_op = 4'd14; req_a = 32'd1; req_b = 32'd2; req_shamt = 5'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      failures++; $display("FAIL mid_resp_pre got=v%b e%b exp=v1 e1", rsp_valid, rsp_err);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL mid_resp_reset got=v%b e%b rdy%b exp=v0 e0 rdy1", rsp_valid, rsp_err, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    do_op(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 0, "b2b_and");
    for (int i = 0; i < 3; i++) begin
      t0 = t_acc;
      do_op(4'(i + 3), $urandom, $urandom, 5'($urandom), 0, "b2b");
      checks++;
      if ((t_acc - t0) != time'((SETTLE + 2) * 10)) begin
        failures++; $display("FAIL b2b_spacing got=%0t exp=%0d", t_acc - t0, (SETTLE + 2) * 10);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] corners [6];
    logic [31:0] a, b;
    corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd5};
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      do_op(4'($urandom_range(0, 11)), a, b, 5'($urandom), int'($urandom_range(0, 3)), "rand");
    end
  endtask

`ifdef ALU_STATUS_REG_EN
  task automatic test_status_reg();
    apply_reset();
    do_op(4'd1, 32'd3, 32'd5, 5'd0, 0, "status_sub");
    checks++;
    if (status_flags !== 4'b0100) begin failures++; $display("FAIL status_after_sub got=%b exp=0100", status_flags); end
    do_op(4'd13, 32'd0, 32'd0, 5'd0, 1, "status_illegal");
    checks++;
    if (status_flags !== 4'b0100) begin failures++; $display("FAIL status_after_illegal got=%b exp=0100", status_flags); end
  endtask
`endif

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_shamt = '0;
    last_a = '0; last_b = '0; last_ctrl = '0; last_sh = '0; st_exp = '0; t_acc = 0;
    test_reset();
    test_directed();
    test_reset_mid_flight();
    test_back_to_back();
    test_random();
`ifdef ALU_STATUS_REG_EN
    test_status_reg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
